// File: rtl/day10_pkg.sv
`default_nettype none
// ============================================================================
// Module      : day10_pkg
// Description : Shared width helpers, FSM state encoding and popcount for the
//               streaming button-press solver.
// Revision    : 1.0 - initial release
// ============================================================================
package day10_pkg;

   // Width needed to hold a button count 0..max_buttons.
   function automatic int btn_cnt_w(input int max_buttons);
      return $clog2(max_buttons + 1);
   endfunction

   // A press count never exceeds the button count, so it shares that width.
   function automatic int press_w(input int max_buttons);
      return $clog2(max_buttons + 1);
   endfunction

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SEARCH = 2'd1;
   localparam state_t ST_EMIT   = 2'd2;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, v[i]};
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/day10_press_solver_if.sv
`default_nettype none
// ============================================================================
// Module      : day10_press_solver_if
// Description : Descriptor-in / result-out bundle of the press solver.
//               master = producer/consumer side, slave = solver side.
// Revision    : 1.0 - initial release
// ============================================================================
interface day10_press_solver_if
   import day10_pkg::*;
#(
   parameter int MAX_NUM_LIGHTS  = 10,
   parameter int MAX_NUM_BUTTONS = 13,
   parameter int SUM_W           = 32
);
   localparam int BTN_CNT_W = btn_cnt_w(MAX_NUM_BUTTONS);
   localparam int PRESS_W   = press_w(MAX_NUM_BUTTONS);

   logic                                  in_valid;
   logic                                  in_ready;
   logic [BTN_CNT_W-1:0]                  in_num_buttons;
   logic [MAX_NUM_LIGHTS-1:0]             in_target;
   logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons;
   logic                                  in_last;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [PRESS_W-1:0]                    out_presses;
   logic                                  out_solvable;
   logic                                  out_last;
   logic                                  sum_valid;
   logic [SUM_W-1:0]                      sum;
   logic                                  busy;

   modport master (
      output in_valid, in_num_buttons, in_target, in_buttons, in_last, out_ready,
      input  in_ready, out_valid, out_presses, out_solvable, out_last,
             sum_valid, sum, busy
   );

   modport slave (
      input  in_valid, in_num_buttons, in_target, in_buttons, in_last, out_ready,
      output in_ready, out_valid, out_presses, out_solvable, out_last,
             sum_valid, sum, busy
   );
endinterface
`default_nettype wire

// File: rtl/day10_lane_eval.sv
`default_nettype none
// ============================================================================
// Module      : day10_lane_eval
// Description : Combinational evaluation of one candidate press mask: is it
//               in range, does its XOR of buttons hit the target, how many
//               presses does it use.
// Revision    : 1.0 - initial release
// ============================================================================
module day10_lane_eval
   import day10_pkg::*;
#(
   parameter  int MAX_NUM_LIGHTS  = 10,
   parameter  int MAX_NUM_BUTTONS = 13,
   localparam int BTN_CNT_W       = btn_cnt_w(MAX_NUM_BUTTONS),
   localparam int PRESS_W         = press_w(MAX_NUM_BUTTONS),
   localparam int MW              = MAX_NUM_BUTTONS + 1
) (
   input  wire logic [MW-1:0]                             i_mask,
   input  wire logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] i_buttons,
   input  wire logic [BTN_CNT_W-1:0]                      i_num_buttons,
   input  wire logic [MAX_NUM_LIGHTS-1:0]                 i_target,
   output logic                                           o_active,
   output logic                                           o_match,
   output logic [PRESS_W-1:0]                             o_popcount
);
   localparam int LW = MW + 1;

   logic [LW-1:0]             w_limit;
   logic [MAX_NUM_LIGHTS-1:0] w_xor;

   assign w_limit  = LW'(1) << i_num_buttons;
   assign o_active = {1'b0, i_mask} < w_limit;

   // XOR the selected buttons; buttons beyond the machine's count never count.
   always_comb begin
      w_xor = '0;
      for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
         if (i_mask[b] && (b < int'(i_num_buttons)))
            w_xor = w_xor ^ i_buttons[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS];
      end
   end

   assign o_match    = o_active && (w_xor == i_target);
   assign o_popcount = PRESS_W'(popcount32(32'(i_mask)));
endmodule
`default_nettype wire

// File: rtl/day10_press_solver.sv
`default_nettype none
// ============================================================================
// Module      : day10_press_solver
// Description : Streaming minimum-press solver. Exhaustively sweeps press
//               masks NUM_LANES at a time, emits one result per machine and a
//               running total at each end-of-batch descriptor.
// Revision    : 1.0 - initial release
// ============================================================================
module day10_press_solver
   import day10_pkg::*;
#(
   parameter int MAX_NUM_LIGHTS  = 10,
   parameter int MAX_NUM_BUTTONS = 13,
   parameter int NUM_LANES       = 4,
   parameter int SUM_W           = 32
) (
   input wire logic            clk,
   input wire logic            rst_n,
   day10_press_solver_if.slave bus
);
   localparam int BTN_CNT_W = btn_cnt_w(MAX_NUM_BUTTONS);
   localparam int PRESS_W   = press_w(MAX_NUM_BUTTONS);
   localparam int MW        = MAX_NUM_BUTTONS + 1;
   localparam int BW        = MW + 1;
   localparam logic [BTN_CNT_W-1:0] c_max_btn = BTN_CNT_W'(MAX_NUM_BUTTONS);

   state_t                                  r_state;
   logic [BTN_CNT_W-1:0]                    r_num_buttons;
   logic [MAX_NUM_LIGHTS-1:0]               r_target;
   logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] r_buttons;
   logic                                    r_last;
   logic [MW-1:0]                           r_base;
   logic [PRESS_W-1:0]                      r_best;
   logic                                    r_found;
   logic [SUM_W-1:0]                        r_acc;
   logic [SUM_W-1:0]                        r_sum;
   logic                                    r_sum_valid;

   logic [BTN_CNT_W-1:0]    w_in_nb;
   logic [BW-1:0]           w_limit;
   logic [BW-1:0]           w_next_base;
   logic                    w_search_done;
   logic [PRESS_W-1:0]      w_result;
   logic [SUM_W-1:0]        w_acc_add;
   logic [MW-1:0]           w_mask   [NUM_LANES];
   logic [PRESS_W-1:0]      w_pop    [NUM_LANES];
   logic [NUM_LANES-1:0]    w_match;
   logic [NUM_LANES-1:0]    w_active;
   logic                    w_node_valid [1:2*NUM_LANES-1];
   logic [PRESS_W-1:0]      w_node_val   [1:2*NUM_LANES-1];

   assign w_in_nb       = (bus.in_num_buttons > c_max_btn) ? c_max_btn : bus.in_num_buttons;
   assign w_limit       = BW'(1) << r_num_buttons;
   assign w_next_base   = {1'b0, r_base} + BW'(NUM_LANES);
   assign w_search_done = w_next_base >= w_limit;
   assign w_result      = r_found ? r_best : '0;
   assign w_acc_add     = r_acc + SUM_W'(w_result);

   generate
      for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
         assign w_mask[gl] = r_base + MW'(gl);
         day10_lane_eval #(
            .MAX_NUM_LIGHTS (MAX_NUM_LIGHTS),
            .MAX_NUM_BUTTONS(MAX_NUM_BUTTONS)
         ) u_lane (
            .i_mask       (w_mask[gl]),
            .i_buttons    (r_buttons),
            .i_num_buttons(r_num_buttons),
            .i_target     (r_target),
            .o_active     (w_active[gl]),
            .o_match      (w_match[gl]),
            .o_popcount   (w_pop[gl])
         );
      end
   endgenerate

   // Heap-ordered min tree: leaves at NUM_LANES.., node i merges 2i and 2i+1.
   always_comb begin
      for (int i = 1; i < 2*NUM_LANES; i++) begin
         w_node_valid[i] = 1'b0;
         w_node_val[i]   = '0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         w_node_valid[NUM_LANES+l] = w_match[l];
         w_node_val[NUM_LANES+l]   = w_pop[l];
      end
      for (int i = NUM_LANES - 1; i >= 1; i--) begin
         w_node_valid[i] = w_node_valid[2*i] | w_node_valid[2*i+1];
         w_node_val[i]   = (w_node_valid[2*i] &&
                            (!w_node_valid[2*i+1] || (w_node_val[2*i] <= w_node_val[2*i+1])))
                           ? w_node_val[2*i] : w_node_val[2*i+1];
      end
   end

   // Control FSM, search bookkeeping and batch accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_num_buttons <= '0;
         r_target      <= '0;
         r_buttons     <= '0;
         r_last        <= 1'b0;
         r_base        <= '0;
         r_best        <= '1;
         r_found       <= 1'b0;
         r_acc         <= '0;
         r_sum         <= '0;
         r_sum_valid   <= 1'b0;
      end else begin
         r_sum_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_num_buttons <= w_in_nb;
                  r_target      <= bus.in_target;
                  r_buttons     <= bus.in_buttons;
                  r_last        <= bus.in_last;
                  r_base        <= '0;
                  r_best        <= '1;
                  r_found       <= 1'b0;
                  r_state       <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (|w_active && w_node_valid[1]) begin
                  r_found <= 1'b1;
                  if (w_node_val[1] < r_best) r_best <= w_node_val[1];
               end
               r_base <= w_next_base[MW-1:0];
               if (w_search_done) r_state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  if (r_last) begin
                     r_sum       <= w_acc_add;
                     r_sum_valid <= 1'b1;
                     r_acc       <= '0;
                  end else begin
                     r_acc <= w_acc_add;
                  end
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (r_state == ST_IDLE);
   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.out_valid    = (r_state == ST_EMIT);
   assign bus.out_presses  = (r_state == ST_EMIT) ? w_result : '0;
   assign bus.out_solvable = (r_state == ST_EMIT) && r_found;
   assign bus.out_last     = (r_state == ST_EMIT) && r_last;
   assign bus.sum_valid    = r_sum_valid;
   assign bus.sum          = r_sum;
endmodule
`default_nettype wire
